vga_fill_scheduler: RTL
=======================

// Module: vga_fill_scheduler
// PURPOSE
//   Shares the write port of the display RAM between N_REQ drawing clients (menu, price, status
//   renderers). Round-robin arbitration picks one rectangle-fill command; an FSM then streams one
//   12-bit RGB pixel per enabled cycle into the frame buffer (addr = y*H_RES + x), clipped to the
//   visible area. Writes can be gated to blanking so the scan-out read port never sees tearing.
// PARAMETERS
//   N_REQ      2    number of requesters (1..4)
//   H_RES      640  frame-buffer width in pixels (row stride)
//   V_RES      480  frame-buffer height in lines
//   GATE_BLANK 1    1: write only while blank=1; 0: write every cycle
// PORTS
//   clk        in   1         pixel clock (same domain as VGA timing and display RAM)
//   rst_n      in   1         asynchronous, active-low reset
//   blank      in   1         1 = VGA timing is outside the visible area
//   abort      in   1         sync; terminates the current fill early
//   req_valid  in   N_REQ     per-requester command valid
//   req_ready  out  N_REQ     one-hot accept; transfer when valid&ready
//   req_x      in   10*N_REQ  top-left x per requester (packed, req i at [10i+:10])
//   req_y      in   10*N_REQ  top-left y
//   req_w      in   10*N_REQ  width in pixels
//   req_h      in   10*N_REQ  height in lines
//   req_colour in   12*N_REQ  fill colour {R[11:8],G[7:4],B[3:0]}
//   ram_we     out  1         display RAM write enable (registered)
//   ram_addr   out  19        display RAM write address (registered)
//   ram_din    out  12        display RAM write data (registered)
//   busy       out  1         1 in SETUP/FILL/DONE
//   done       out  1         1-cycle pulse at command completion
//   done_id    out  2         requester index of completed command (valid with done)
//   done_abort out  1         1 if completion was due to abort (valid with done)
// BEHAVIOUR
//   Reset: state IDLE; ram_we/ram_addr/ram_din/req_ready/busy/done/done_id/done_abort = 0;
//     rr pointer = N_REQ-1 (requester 0 wins first). Reset mid-fill discards command, no done.
//   IDLE: req_ready combinational from state+req_valid; grant = first valid index after the
//     last grant, cyclically. Exactly one ready bit high, only in IDLE. On transfer latch fields,
//     update pointer, -> SETUP. Requester holds fields stable while valid; dropping valid early is
//     legal and accepts nothing.
//   SETUP (1 cycle): x_end = min(x+w, H_RES), y_end = min(y+h, V_RES) in 11 bits (no wrap);
//     if w==0 | h==0 | x>=H_RES | y>=V_RES -> DONE (no writes); else row_base = y*H_RES,
//     cur_x = x, cur_y = y -> FILL.
//   FILL: pixel enable pe = !GATE_BLANK | blank. On pe: ram_we=1, ram_addr=row_base+cur_x,
//     ram_din=colour; cur_x++; at cur_x==x_end-1 wrap cur_x=x, row_base+=H_RES, cur_y++.
//     After last pixel (cur_x==x_end-1 & cur_y==y_end-1) -> DONE. !pe: ram_we=0, counters hold.
//   abort in FILL or SETUP -> DONE with done_abort=1; pixel in same cycle is not written.
//     abort in IDLE/DONE ignored.
//   DONE (1 cycle): done=1, done_id, done_abort; -> IDLE. New grant earliest next cycle.
//   Latency: accept -> first write = 2 cycles (SETUP, then registered write) if pe.
//     Last write -> done pulse: next cycle. ram_we low in every non-FILL cycle.
//   Address arithmetic 19 bits; max H_RES*V_RES = 307200 fits; no multiplier beyond constant y*H_RES.
// STRUCTURE
//   vga_pkg: H_RES/V_RES defaults, ADDR_W=19, COLOUR_W=12, COORD_W=10, state enum
//     {IDLE,SETUP,FILL,DONE}.
//   Sub-module rr_arbiter (N_REQ req in, one-hot grant + index out, pointer update on accept).
//   FSM, clipping and address generation in this module.
// TESTING
//   1 GATE_BLANK=0, req0 x=10 y=2 w=3 h=2 c=12'hF00 -> writes 1290,1291,1292,1930,1931,1932
//     all din F00; done=1 id=0 abort=0 one cycle after last write.
//   2 req0, req1 held valid continuously -> grants 0,1,0,1; never two ready bits in one cycle.
//   3 x=638 w=5 y=479 h=4 -> exactly two writes: 307198, 307199; then done.
//   4 w=0 (or x=700) -> zero ram_we cycles, done 2 cycles after accept.
//   5 GATE_BLANK=1, blank toggled 0/1 during 4x1 fill -> writes only when blank=1, addresses
//     contiguous, none skipped or repeated.
//   6 abort after 3rd write of 8x8 fill -> no further writes, done_abort=1; rst_n low mid-fill
//     -> ram_we=0 immediately, no done, next request served normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the frame-buffer rectangle fill scheduler.
//   Frame-buffer geometry defaults, bus widths, FSM state encoding, the
//   latched fill-command payload and the clipping helper.
package vga_pkg;

   localparam int unsigned H_RES_DEF = 640;
   localparam int unsigned V_RES_DEF = 480;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned COLOUR_W  = 12;
   localparam int unsigned COORD_W   = 10;
   // One extra bit so x+w / y+h never wrap before clipping.
   localparam int unsigned LEN_W     = COORD_W + 1;
   localparam int unsigned ID_W      = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } fill_state_t;

   typedef struct packed {
      logic [COORD_W-1:0]  x;
      logic [COORD_W-1:0]  y;
      logic [COORD_W-1:0]  w;
      logic [COORD_W-1:0]  h;
      logic [COLOUR_W-1:0] colour;
   } fill_cmd_t;

   // Exclusive end coordinate of a span, clipped to the visible limit.
   function automatic logic [LEN_W-1:0] clip_end(input logic [COORD_W-1:0] start,
                                                 input logic [COORD_W-1:0] len,
                                                 input logic [LEN_W-1:0]   limit);
      logic [LEN_W-1:0] sum;
      sum = LEN_W'(start) + LEN_W'(len);
      return (sum > limit) ? limit : sum;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the fill-command requesters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester valid
//   accept       : the current grant is being taken; advances the pointer
//   grant_c      : one-hot grant (combinational)
//   grant_idx_c  : index of the granted requester (combinational)
//   grant_any_c  : at least one requester is valid (combinational)
module rr_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned N_REQ = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             accept,
   output logic [N_REQ-1:0] grant_c,
   output logic [ID_W-1:0]  grant_idx_c,
   output logic             grant_any_c
);

   logic [ID_W-1:0] last_q;

   // Pick the first valid requester after the last grant, cyclically.
   // Offsets are scanned from farthest to nearest so the nearest one wins.
   always_comb begin
      grant_idx_c = '0;
      grant_any_c = 1'b0;
      grant_c     = '0;
      for (int off = int'(N_REQ); off >= 1; off--) begin
         for (int j = 0; j < int'(N_REQ); j++) begin
            if (req[j] && (j == ((int'(last_q) + off) % int'(N_REQ)))) begin
               grant_idx_c = ID_W'(j);
               grant_any_c = 1'b1;
            end
         end
      end
      for (int j = 0; j < int'(N_REQ); j++) begin
         grant_c[j] = grant_any_c && (grant_idx_c == ID_W'(j));
      end
   end

   // Pointer starts at the last index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= ID_W'(N_REQ - 1);
      end else if (accept) begin
         last_q <= grant_idx_c;
      end
   end

endmodule

// File: rtl/vga_fill_scheduler.sv
// Rectangle-fill scheduler for the display RAM write port.
//   Arbitrates between N_REQ drawing clients, then streams one pixel per
//   enabled cycle of the granted rectangle (clipped to the visible area)
//   into the frame buffer at addr = y*H_RES + x.
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   blank             : VGA timing outside the visible area
//   abort             : ends the current fill early
//   req_valid/ready   : per-requester handshake (ready one-hot, IDLE only)
//   req_x/y/w/h       : packed 10-bit rectangle fields, requester i at [10i+:10]
//   req_colour        : packed 12-bit RGB fill colour, requester i at [12i+:12]
//   ram_we/addr/din   : registered display RAM write port
//   busy              : command in flight (SETUP/FILL/DONE)
//   done/done_id/done_abort : completion pulse with requester index and abort flag
module vga_fill_scheduler
   import vga_pkg::*;
#(
   parameter int unsigned N_REQ      = 2,
   parameter int unsigned H_RES      = H_RES_DEF,
   parameter int unsigned V_RES      = V_RES_DEF,
   parameter bit          GATE_BLANK = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        blank,
   input  logic                        abort,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [COORD_W*N_REQ-1:0]    req_x,
   input  logic [COORD_W*N_REQ-1:0]    req_y,
   input  logic [COORD_W*N_REQ-1:0]    req_w,
   input  logic [COORD_W*N_REQ-1:0]    req_h,
   input  logic [COLOUR_W*N_REQ-1:0]   req_colour,
   output logic                        ram_we,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [COLOUR_W-1:0]         ram_din,
   output logic                        busy,
   output logic                        done,
   output logic [ID_W-1:0]             done_id,
   output logic                        done_abort
);

   logic [N_REQ-1:0]   grant_c;
   logic [ID_W-1:0]    grant_idx_c;
   logic               grant_any_c;
   logic               accept_c;

   fill_state_t        state;
   fill_cmd_t          sel_cmd_c;
   fill_cmd_t          cmd;
   logic [ID_W-1:0]    cmd_id;
   logic               abort_q;
   logic [LEN_W-1:0]   x_end;
   logic [LEN_W-1:0]   y_end;
   logic [COORD_W-1:0] cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [ADDR_W-1:0]  row_base;

   logic               pe_c;
   logic               last_col_c;
   logic               last_row_c;
   logic               empty_c;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_valid),
      .accept      (accept_c),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c),
      .grant_any_c (grant_any_c)
   );

   // A grant is only offered while idle; ready implies valid, so offer == transfer.
   assign accept_c  = (state == IDLE) && grant_any_c;
   assign req_ready = (state == IDLE) ? grant_c : '0;

   // Unpack the granted requester's command fields.
   always_comb begin
      sel_cmd_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_idx_c == ID_W'(i)) begin
            sel_cmd_c.x      = req_x[COORD_W*i +: COORD_W];
            sel_cmd_c.y      = req_y[COORD_W*i +: COORD_W];
            sel_cmd_c.w      = req_w[COORD_W*i +: COORD_W];
            sel_cmd_c.h      = req_h[COORD_W*i +: COORD_W];
            sel_cmd_c.colour = req_colour[COLOUR_W*i +: COLOUR_W];
         end
      end
   end

   // Pixel enable: with gating, write only while scan-out is in blanking.
   assign pe_c = (GATE_BLANK == 1'b0) || blank;

   // Nothing visible to draw: zero-sized or starting off-screen.
   assign empty_c = (cmd.w == '0) || (cmd.h == '0) ||
                    (LEN_W'(cmd.x) >= LEN_W'(H_RES)) ||
                    (LEN_W'(cmd.y) >= LEN_W'(V_RES));

   assign last_col_c = (LEN_W'(cur_x) == (x_end - LEN_W'(1)));
   assign last_row_c = (LEN_W'(cur_y) == (y_end - LEN_W'(1)));

   // Command FSM with clipping and address generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd        <= '0;
         cmd_id     <= '0;
         abort_q    <= 1'b0;
         x_end      <= '0;
         y_end      <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         row_base   <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_id    <= '0;
         done_abort <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  cmd     <= sel_cmd_c;
                  cmd_id  <= grant_idx_c;
                  abort_q <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SETUP;
               end
            end

            SETUP: begin
               x_end    <= clip_end(cmd.x, cmd.w, LEN_W'(H_RES));
               y_end    <= clip_end(cmd.y, cmd.h, LEN_W'(V_RES));
               cur_x    <= cmd.x;
               cur_y    <= cmd.y;
               // Constant-coefficient multiply; only used when y is on-screen.
               row_base <= ADDR_W'(cmd.y) * ADDR_W'(H_RES);
               if (abort) begin
                  abort_q <= 1'b1;
                  state   <= DONE;
               end else if (empty_c) begin
                  state <= DONE;
               end else begin
                  state <= FILL;
               end
            end

            FILL: begin
               if (abort) begin
                  abort_q <= 1'b1;
                  state   <= DONE;
               end else if (pe_c) begin
                  ram_we   <= 1'b1;
                  ram_addr <= row_base + ADDR_W'(cur_x);
                  ram_din  <= cmd.colour;
                  if (last_col_c) begin
                     if (last_row_c) begin
                        state <= DONE;
                     end else begin
                        cur_x    <= cmd.x;
                        cur_y    <= cur_y + COORD_W'(1);
                        row_base <= row_base + ADDR_W'(H_RES);
                     end
                  end else begin
                     cur_x <= cur_x + COORD_W'(1);
                  end
               end
            end

            DONE: begin
               done       <= 1'b1;
               done_id    <= cmd_id;
               done_abort <= abort_q;
               busy       <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
